mul_seq_engine: RTL and testbench

Iterative 32x32 -> 64-bit multiplier serving the execute stage's `mul`/`done` handshake. Execute holds `mul` high and stalls (`stall = mul & ~done`) until this block returns `done`. The 64-bit product then drives the FP register write bus. This block is the responder side of that handshake: it captures the operands and runs one shift-add step per cycle, then presents the product for exactly one cycle.

---
 rtl/mul_seq_engine.sv | 145 ++++++++++++++
 tb/tb_mul_seq_engine.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/mul_seq_engine.sv
// Iterative 32x32 -> 64 shift-add multiplier answering the execute stage mul/done handshake.
// Define MUL_SIGNED_EN for two's-complement operands (sign-magnitude around the unsigned core).
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | waiting for mul; captures operands on the edge where mul is high
// BUSY  | one shift-add iteration per cycle; mul low aborts to IDLE
// DONE  | product valid for one cycle; always returns to IDLE
module mul_seq_engine #(
    parameter int WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 mul,
    input  logic [0:WIDTH-1]     a,
    input  logic [0:WIDTH-1]     b,
    output logic                 done,
    output logic [0:2*WIDTH-1]   result,
    output logic                 busy
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_BUSY,
        S_DONE
    } state_t;

    state_t               state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [WIDTH-1:0]     mcand_q, mcand_d;
    logic [WIDTH-1:0]     hi_q, hi_d;
    logic [WIDTH-1:0]     lo_q, lo_d;
    logic [2*WIDTH-1:0]   result_q, result_d;

    logic [WIDTH-1:0]     a_v, b_v;
    logic [WIDTH-1:0]     a_op, b_op;
    logic [WIDTH:0]       sum;
    logic [WIDTH-1:0]     hi_next, lo_next;
    logic [2*WIDTH-1:0]   prod_next;
    logic [2*WIDTH-1:0]   prod_final;

    // Ports are MSB-at-index-0; plain assignment maps them onto numeric vectors.
    assign a_v = a;
    assign b_v = b;

`ifdef MUL_SIGNED_EN
    logic sign_q, sign_d;

    // Negating 0x80000000 yields 0x80000000, which is the correct 2^31 magnitude as unsigned.
    assign a_op       = a_v[WIDTH-1] ? -a_v : a_v;
    assign b_op       = b_v[WIDTH-1] ? -b_v : b_v;
    assign prod_final = sign_q ? -prod_next : prod_next;
`else
    assign a_op       = a_v;
    assign b_op       = b_v;
    assign prod_final = prod_next;
`endif

    // hi holds the upper accumulator half, lo holds the lower half with the remaining multiplier bits.
    always_comb begin
        sum = {1'b0, hi_q};
        if (lo_q[0]) begin
            sum = {1'b0, hi_q} + {1'b0, mcand_q};
        end
        hi_next   = sum[WIDTH:1];
        lo_next   = {sum[0], lo_q[WIDTH-1:1]};
        prod_next = {hi_next, lo_next};
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        mcand_d  = mcand_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        result_d = result_q;
`ifdef MUL_SIGNED_EN
        sign_d   = sign_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (mul) begin
                    mcand_d = a_op;
                    lo_d    = b_op;
                    hi_d    = '0;
                    cnt_d   = '0;
`ifdef MUL_SIGNED_EN
                    sign_d  = a_v[WIDTH-1] ^ b_v[WIDTH-1];
`endif
                    state_d = S_BUSY;
                end
            end
            S_BUSY: begin
                if (!mul) begin
                    state_d = S_IDLE;
                end else begin
                    hi_d  = hi_next;
                    lo_d  = lo_next;
                    cnt_d = cnt_q + CW'(1);
                    if (cnt_q == CW'(WIDTH - 1)) begin
                        result_d = prod_final;
                        state_d  = S_DONE;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            mcand_q  <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            result_q <= '0;
`ifdef MUL_SIGNED_EN
            sign_q   <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            mcand_q  <= mcand_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            result_q <= result_d;
`ifdef MUL_SIGNED_EN
            sign_q   <= sign_d;
`endif
        end
    end

    assign done   = (state_q == S_DONE);
    assign busy   = (state_q == S_BUSY);
    assign result = result_q;

endmodule

// File: tb/tb_mul_seq_engine.sv
// Directed bench for mul_seq_engine: latency, products, abort, mid-operation reset, back-to-back.
// Expected products follow MUL_SIGNED_EN the same way the design build does.
module tb_mul_seq_engine;

    logic         clk = 1'b0;
    logic         reset;
    logic         mul;
    logic [0:31]  a;
    logic [0:31]  b;
    logic         done;
    logic         busy;
    logic [0:63]  result;

    int n_pass  = 0;
    int n_total = 0;
    int cyc;
    logic saw_done;

    always #5 clk = ~clk;

    mul_seq_engine #(.WIDTH(32)) dut (
        .clk    (clk),
        .reset  (reset),
        .mul    (mul),
        .a      (a),
        .b      (b),
        .done   (done),
        .result (result),
        .busy   (busy)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Request at an IDLE point, scramble operands after capture, expect done on the 33rd edge.
    task automatic run_mul(input logic [31:0] av, input logic [31:0] bv,
                           input logic [63:0] exp, input string tag);
        int n;
        a   = av;
        b   = bv;
        mul = 1'b1;
        tick();
        chk({tag, " busy after capture"}, {63'd0, busy}, 64'd1);
        chk({tag, " no early done"}, {63'd0, done}, 64'd0);
        a = $urandom;
        b = $urandom;
        n = 1;
        while (!done && n < 60) begin
            tick();
            n++;
        end
        chk({tag, " latency"}, 64'(n), 64'd33);
        chk({tag, " product"}, result, exp);
        mul = 1'b0;
        tick();
        chk({tag, " done one cycle"}, {62'd0, done, busy}, 64'd0);
        chk({tag, " result held"}, result, exp);
    endtask

    initial begin
        reset = 1'b0;
        mul   = 1'b0;
        a     = '0;
        b     = '0;
        repeat (3) tick();
        chk("reset done/busy", {62'd0, done, busy}, 64'd0);
        chk("reset result", result, 64'd0);
        reset = 1'b1;
        repeat (2) tick();
        chk("idle without mul", {62'd0, done, busy}, 64'd0);

        run_mul(32'd3, 32'd5, 64'h0000_0000_0000_000F, "3x5");
`ifdef MUL_SIGNED_EN
        run_mul(32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'h0000_0000_0000_0001, "m1xm1");
        run_mul(32'hFFFF_FFFE, 32'd3, 64'hFFFF_FFFF_FFFF_FFFA, "m2x3");
        run_mul(32'hFFFF_FFF9, 32'd9, 64'hFFFF_FFFF_FFFF_FFC1, "m7x9");
`else
        run_mul(32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, "maxxmax");
        run_mul(32'hFFFF_FFFE, 32'd3, 64'h0000_0002_FFFF_FFFA, "fffffffex3");
        run_mul(32'hFFFF_FFF9, 32'd9, 64'h0000_0008_FFFF_FFC1, "fffffff9x9");
`endif
        run_mul(32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000, "minxmin");

        // Abort after 10 BUSY cycles: no done, result keeps the previous product.
        a   = 32'd7;
        b   = 32'd9;
        mul = 1'b1;
        tick();
        saw_done = 1'b0;
        repeat (10) begin
            tick();
            if (done) saw_done = 1'b1;
        end
        chk("abort still busy", {63'd0, busy}, 64'd1);
        mul = 1'b0;
        tick();
        chk("abort to idle", {62'd0, done, busy}, 64'd0);
        chk("abort never done", {63'd0, saw_done}, 64'd0);
        chk("abort result held", result, 64'h4000_0000_0000_0000);
        tick();
        run_mul(32'd7, 32'd9, 64'h0000_0000_0000_003F, "7x9 retry");

        // One-cycle reset on iteration 20 with mul held; recapture on the next edge.
        a   = 32'd11;
        b   = 32'd13;
        mul = 1'b1;
        tick();
        repeat (19) tick();
        chk("pre-reset busy", {63'd0, busy}, 64'd1);
        reset = 1'b0;
        tick();
        chk("midop reset idle", {62'd0, done, busy}, 64'd0);
        chk("midop reset result", result, 64'd0);
        reset = 1'b1;
        cyc = 0;
        do begin
            tick();
            cyc++;
        end while (!done && cyc < 60);
        chk("post-reset latency", 64'(cyc), 64'd33);
        chk("post-reset product", result, 64'd143);
        mul = 1'b0;
        tick();

        // Back-to-back with mul held: DONE, one IDLE cycle, then the second run.
        a   = 32'd2;
        b   = 32'd3;
        mul = 1'b1;
        cyc = 0;
        do begin
            tick();
            cyc++;
        end while (!done && cyc < 60);
        chk("b2b first latency", 64'(cyc), 64'd33);
        chk("b2b first product", result, 64'd6);
        a = 32'h0001_0000;
        b = 32'h0001_0000;
        tick();
        chk("b2b idle gap", {62'd0, done, busy}, 64'd0);
        chk("b2b gap result", result, 64'd6);
        cyc = 1;
        while (!done && cyc < 80) begin
            tick();
            cyc++;
        end
        // 34 edges separate the two done cycles; counted inclusively that is a 35-cycle span.
        chk("b2b done spacing", 64'(cyc), 64'd34);
        chk("b2b second product", result, 64'h0000_0001_0000_0000);
        mul = 1'b0;
        tick();
        chk("b2b final idle", {62'd0, done, busy}, 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
